// File: rtl/toast_redirect_ctrl_if.sv
// ID/IF-side signal bundle for the PC redirect controller.
// The slave modport is the controller; master is the ID/IF side driving it.
interface toast_redirect_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 ID_valid_i;
    logic                 ID_branch_taken_i;
    logic [1:0]           ID_branch_op_i;
    logic [31:0]          ID_pc_dest_i;
    logic                 hazard_stall_i;
    logic                 IF_ready_i;
    logic                 pc_sel_o;
    logic [31:0]          pc_target_o;
    logic                 IF_flush_o;
    logic                 pc_hold_o;
    logic                 misalign_o;
    logic                 busy_o;
    logic [CNT_WIDTH-1:0] redirect_count_o;

    modport master (
        output ID_valid_i, ID_branch_taken_i, ID_branch_op_i, ID_pc_dest_i,
               hazard_stall_i, IF_ready_i,
        input  pc_sel_o, pc_target_o, IF_flush_o, pc_hold_o, misalign_o,
               busy_o, redirect_count_o
    );

    modport slave (
        input  ID_valid_i, ID_branch_taken_i, ID_branch_op_i, ID_pc_dest_i,
               hazard_stall_i, IF_ready_i,
        output pc_sel_o, pc_target_o, IF_flush_o, pc_hold_o, misalign_o,
               busy_o, redirect_count_o
    );
endinterface

// File: rtl/toast_redirect_ctrl.sv
// PC redirect sequencer for branches/jumps resolved in ID: zero-latency redirect
// when IF is ready, otherwise holds the target until IF accepts, then a flush window.
module toast_redirect_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk_i,
    input  logic                    resetn_i,
    toast_redirect_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {S_IDLE, S_PEND, S_FLUSH} state_t;

    localparam logic [2:0] FC_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam bit         HAS_WIN = (FLUSH_CYCLES > 1);

    state_t               r_state, w_next;
    logic [31:0]          r_tgt;
    logic [2:0]           r_fcnt;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic [31:0] w_tgt;
    logic        w_req, w_go, w_accept, w_latch;
    logic        w_sel, w_flush, w_hold, w_mis;
    logic [31:0] w_pc_tgt;

    // JALR targets have bit 0 cleared; pc-relative targets pass through untouched.
    assign w_tgt    = bus.ID_branch_op_i[1] ? {bus.ID_pc_dest_i[31:1], 1'b0} : bus.ID_pc_dest_i;
    assign w_req    = bus.ID_valid_i & bus.ID_branch_taken_i & ~bus.hazard_stall_i
                    & (bus.ID_branch_op_i != 2'b00);
    assign w_go     = (r_state == S_IDLE) & w_req & ~w_tgt[1];
    assign w_accept = (w_go | (r_state == S_PEND)) & bus.IF_ready_i;
    assign w_latch  = w_go & ~bus.IF_ready_i;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state <= S_IDLE;
            r_tgt   <= '0;
            r_fcnt  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch)
                r_tgt <= w_tgt;
            if (w_accept)
                r_fcnt <= FC_LOAD;
            else if (r_state == S_FLUSH)
                r_fcnt <= r_fcnt - 3'd1;
            r_cnt <= r_cnt + CNT_WIDTH'(w_accept);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_go)
                         w_next = !bus.IF_ready_i ? S_PEND : (HAS_WIN ? S_FLUSH : S_IDLE);
            S_PEND:  if (bus.IF_ready_i)
                         w_next = HAS_WIN ? S_FLUSH : S_IDLE;
            S_FLUSH: if (r_fcnt <= 3'd1)
                         w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_sel    = 1'b0;
        w_flush  = 1'b0;
        w_hold   = 1'b0;
        w_mis    = 1'b0;
        w_pc_tgt = '0;
        case (r_state)
            S_IDLE: begin
                w_mis = w_req & w_tgt[1];
                if (w_go) begin
                    w_flush  = 1'b1;
                    w_sel    = bus.IF_ready_i;
                    w_hold   = ~bus.IF_ready_i;
                    w_pc_tgt = bus.IF_ready_i ? w_tgt : 32'd0;
                end
            end
            S_PEND: begin
                w_sel    = 1'b1;
                w_flush  = 1'b1;
                w_hold   = ~bus.IF_ready_i;
                w_pc_tgt = r_tgt;
            end
            S_FLUSH: w_flush = 1'b1;
            default: ;
        endcase
    end

    // Combinational paths from ID are masked so every output reads 0 in reset.
    assign bus.pc_sel_o         = w_sel & resetn_i;
    assign bus.pc_target_o      = resetn_i ? w_pc_tgt : 32'd0;
    assign bus.IF_flush_o       = w_flush & resetn_i;
    assign bus.pc_hold_o        = w_hold & resetn_i;
    assign bus.misalign_o       = w_mis & resetn_i;
    assign bus.busy_o           = (r_state != S_IDLE) & resetn_i;
    assign bus.redirect_count_o = r_cnt;
endmodule

// File: tb/tb_toast_redirect_ctrl.sv
// Scoreboard bench: two controllers (flush window 1 and 3) share stimulus and are
// checked each cycle against a behavioural redirect model.
module tb_toast_redirect_ctrl;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    toast_redirect_ctrl_if #(.CNT_WIDTH(32)) bus0 ();
    toast_redirect_ctrl_if #(.CNT_WIDTH(32)) bus1 ();

    toast_redirect_ctrl #(.FLUSH_CYCLES(1), .CNT_WIDTH(32)) dut0 (
        .clk_i(clk), .resetn_i(resetn), .bus(bus0.slave));
    toast_redirect_ctrl #(.FLUSH_CYCLES(3), .CNT_WIDTH(32)) dut1 (
        .clk_i(clk), .resetn_i(resetn), .bus(bus1.slave));

    typedef struct packed {
        logic        sel;
        logic [31:0] tgt;
        logic        flush;
        logic        hold;
        logic        mis;
        logic        busy;
        logic [31:0] cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int checks = 0;
    int errors = 0;

    // Model state: a pending target, remaining flush-window cycles, redirect count.
    bit          m_pend [2];
    logic [31:0] m_ptgt [2];
    int          m_fl   [2];
    logic [31:0] m_cnt  [2];
    int          m_fc   [2] = '{1, 3};

    task automatic drive(input bit v, tk, input logic [1:0] op, input logic [31:0] d,
                         input bit st, rdy);
        bus0.ID_valid_i = v;  bus0.ID_branch_taken_i = tk; bus0.ID_branch_op_i = op;
        bus0.ID_pc_dest_i = d; bus0.hazard_stall_i = st;   bus0.IF_ready_i = rdy;
        bus1.ID_valid_i = v;  bus1.ID_branch_taken_i = tk; bus1.ID_branch_op_i = op;
        bus1.ID_pc_dest_i = d; bus1.hazard_stall_i = st;   bus1.IF_ready_i = rdy;
    endtask

    task automatic cyc(input bit rst_n, v, tk, input logic [1:0] op, input logic [31:0] d,
                       input bit st, rdy);
        @(posedge clk);
        #1;
        resetn = rst_n;
        drive(v, tk, op, d, st, rdy);
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            logic [31:0] tgt;
            bit req;
            e   = '0;
            tgt = op[1] ? (d & 32'hFFFF_FFFE) : d;
            req = v && tk && !st && (op != 2'b00);
            if (!rst_n) begin
                m_pend[k] = 0; m_ptgt[k] = 0; m_fl[k] = 0; m_cnt[k] = 0;
            end else begin
                e.cnt  = m_cnt[k];
                e.busy = m_pend[k] || (m_fl[k] > 0);
                if (m_pend[k]) begin
                    e.sel = 1; e.tgt = m_ptgt[k]; e.flush = 1; e.hold = !rdy;
                    if (rdy) begin
                        m_cnt[k]++; m_pend[k] = 0; m_fl[k] = m_fc[k] - 1;
                    end
                end else if (m_fl[k] > 0) begin
                    e.flush = 1;
                    m_fl[k]--;
                end else if (req) begin
                    if (tgt[1]) e.mis = 1;
                    else begin
                        e.flush = 1;
                        if (rdy) begin
                            e.sel = 1; e.tgt = tgt;
                            m_cnt[k]++; m_fl[k] = m_fc[k] - 1;
                        end else begin
                            e.hold = 1; m_pend[k] = 1; m_ptgt[k] = tgt;
                        end
                    end
                end
            end
            if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic chk(input int k, input exp_t e, input exp_t a);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL dut%0d outputs @%0t: got sel=%b tgt=%h flush=%b hold=%b mis=%b busy=%b cnt=%0d, need sel=%b tgt=%h flush=%b hold=%b mis=%b busy=%b cnt=%0d",
                     k, $time, a.sel, a.tgt, a.flush, a.hold, a.mis, a.busy, a.cnt,
                     e.sel, e.tgt, e.flush, e.hold, e.mis, e.busy, e.cnt);
        end
    endtask

    always @(negedge clk) begin
        exp_t a;
        if (q0.size() > 0) begin
            a = {bus0.pc_sel_o, bus0.pc_target_o, bus0.IF_flush_o, bus0.pc_hold_o,
                 bus0.misalign_o, bus0.busy_o, bus0.redirect_count_o};
            chk(0, q0.pop_front(), a);
        end
        if (q1.size() > 0) begin
            a = {bus1.pc_sel_o, bus1.pc_target_o, bus1.IF_flush_o, bus1.pc_hold_o,
                 bus1.misalign_o, bus1.busy_o, bus1.redirect_count_o};
            chk(1, q1.pop_front(), a);
        end
    end

    initial begin
        drive(0, 0, 2'b00, 32'h0, 0, 0);
        // Reset state, then reset asserted mid-PEND with latched target 0x100
        cyc(0, 0, 0, 2'b00, 32'h0, 0, 0);
        cyc(1, 0, 0, 2'b00, 32'h0, 0, 0);
        cyc(1, 1, 1, 2'b01, 32'h0000_0100, 0, 0);
        cyc(1, 0, 0, 2'b00, 32'h0, 0, 0);
        cyc(0, 1, 1, 2'b01, 32'h0000_0040, 0, 1);
        cyc(1, 0, 0, 2'b00, 32'h0, 0, 1);
        // JAL zero-latency redirect
        cyc(1, 1, 1, 2'b01, 32'h0000_0040, 0, 1);
        repeat (3) cyc(1, 0, 0, 2'b00, 32'h0, 0, 1);
        // JALR bit-0 clear, then misaligned JALR target
        cyc(1, 1, 1, 2'b10, 32'h0000_1235, 0, 1);
        repeat (3) cyc(1, 0, 0, 2'b00, 32'h0, 0, 1);
        cyc(1, 1, 1, 2'b10, 32'h0000_1236, 0, 1);
        cyc(1, 0, 0, 2'b00, 32'h0, 0, 1);
        // Back-pressure: 3 stalled cycles with an ignored second request
        cyc(1, 1, 1, 2'b01, 32'h0000_0080, 0, 0);
        cyc(1, 1, 1, 2'b01, 32'h0000_0200, 0, 0);
        cyc(1, 0, 0, 2'b00, 32'h0, 0, 0);
        cyc(1, 1, 1, 2'b01, 32'h0000_0200, 0, 1);
        repeat (3) cyc(1, 0, 0, 2'b00, 32'h0, 0, 1);
        // Flush window with a request in its second cycle
        cyc(1, 1, 1, 2'b01, 32'h0000_0400, 0, 1);
        cyc(1, 1, 1, 2'b01, 32'h0000_0500, 0, 1);
        repeat (3) cyc(1, 0, 0, 2'b00, 32'h0, 0, 1);
        // Hazard stall suppresses request until released; op=0 never redirects
        cyc(1, 1, 1, 2'b01, 32'h0000_0300, 1, 1);
        cyc(1, 1, 1, 2'b01, 32'h0000_0300, 1, 1);
        cyc(1, 1, 1, 2'b01, 32'h0000_0300, 0, 1);
        repeat (3) cyc(1, 0, 0, 2'b00, 32'h0, 0, 1);
        cyc(1, 1, 1, 2'b00, 32'h0000_0600, 0, 1);
        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] d;
            d = ($urandom() & 32'h0000_FFFC) | ($urandom() % 4);
            cyc(($urandom() % 60) != 0, ($urandom() % 4) != 0, $urandom() % 2,
                2'($urandom() % 4), d, ($urandom() % 5) == 0, ($urandom() % 3) != 0);
        end
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
